ins_fetch_responder: RTL and testbench
======================================

Name: ins_fetch_responder

Overview:
Program-side partner of the instruction register/PC in the ROM-less core. It consumes the 8-bit `Addr` produced by the PC and returns opcode bytes from a writable 256x8 program store. It decodes jump and halt opcodes and drives the PC's parallel-load inputs `PL`/`PL_E` back, closing the fetch loop. Non-control opcodes are presented downstream on `OP`/`OP_V`.

Parameters:
JMP_OPCODE, 8'hF0, two-byte jump: opcode byte followed by 8-bit absolute target
HALT_OPCODE, 8'hFF, stop fetching and hold PC
CNT_W, 16, width of the issued-opcode counter

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  synchronous, active-high reset
Addr  input  8  current PC address from the instruction register
PL  output  8  parallel-load value to the PC
PL_E  output  1  parallel-load enable to the PC
RUN  input  1  1 = execute, 0 = load/idle
WE  input  1  program-store write strobe, honoured only in IDLE
WADDR  input  8  write address
WDATA  input  8  write data
OP  output  8  registered opcode to downstream logic
OP_V  output  1  registered, OP valid for one cycle
HALTED  output  1  1 while in HALT state
FETCH_CNT  output  CNT_W  count of opcodes issued on OP_V, saturating

Behaviour:
- PC contract:
  - PC register loads `PL` when `PL_E`=1, otherwise loads `Addr`.
  - `Addr` = register+1, so each clock advances by 1.
  - To make the next `Addr` equal T, drive `PL_E`=1, `PL`=T-1 mod 256. Target 0 gives `PL`=8'hFF.
- Program store:
  - 256x8, asynchronous read at `Addr`, written on `CLK` when `WE`=1 and state=IDLE.
  - `WE` in any other state is ignored.
  - Store contents are NOT cleared by `RST`.
- `PL`/`PL_E` are combinational (Mealy) from state and `mem[Addr]`. `OP`, `OP_V`, `HALTED`, `FETCH_CNT` are registered.
- Reset (`RST`=1 at an edge): state=IDLE, `OP`=0, `OP_V`=0, `HALTED`=0, `FETCH_CNT`=0. Reset mid-jump or mid-halt aborts to IDLE with no `OP_V`.
- States:
  - IDLE:
    - Outputs: `PL_E`=1, `PL`=8'hFF, so the PC sits at `Addr`=0.
    - `RUN`=1 -> EXEC.
  - EXEC (byte b = `mem[Addr]`):
    - b==HALT_OPCODE: `PL_E`=1, `PL`=`Addr`-1 (hold the PC on the halt byte); next state HALT; no `OP_V`.
    - b==JMP_OPCODE: `PL_E`=0 (PC steps onto the operand); next state TGT; no `OP_V`.
    - otherwise: `PL_E`=0, `PL`=0; next cycle `OP`=b, `OP_V`=1, `FETCH_CNT` += 1, saturating at all-ones; stay in EXEC.
  - TGT (b = target T):
    - Outputs: `PL_E`=1, `PL`=T-1; next state EXEC, so `Addr`=T on the following cycle; no `OP_V`.
    - Jump to a jump (T holds F0) is legal.
    - An operand at `Addr`=255 is fetched normally. Only the PC wraps 255->0, and only when no jump is taken.
  - HALT:
    - Outputs: `HALTED`=1, `PL_E`=1, `PL`=`Addr`-1, so the PC holds.
    - `RUN`=0 -> IDLE.
- `RUN`=0 in EXEC or TGT: abort. Outputs take IDLE values that cycle, next state IDLE, no `OP_V`; a pending jump is discarded.
- Priority: `RST` > `RUN`=0 > opcode decode.
- `OP_V` is a single-cycle pulse per issued opcode. `OP` holds its last value when `OP_V`=0.
- `FETCH_CNT` clears only on `RST`; it is not cleared by IDLE.

Test Plan:
1. Load mem[0..3]=01,02,03,FF with `RUN`=0, then `RUN`=1 -> `OP_V` pulses with `OP`=01,02,03 on consecutive cycles; then `HALTED`=1, `Addr` stays 3, `FETCH_CNT`=3.
2. mem[0]=F0, mem[1]=10, mem[0x10]=AA, mem[0x11]=FF -> `PL_E`=1 with `PL`=0x0F in TGT; next `Addr`=0x10; `OP`=AA; then halt at 0x11; `FETCH_CNT`=1.
3. Jump target 0: mem[0]=05, mem[1]=F0, mem[2]=00 -> `PL`=FF in TGT; the stream 05,05,05... repeats with no gaps beyond the 2-cycle jump bubble.
4. Write attempt during EXEC (`WE`=1, WADDR=0, WDATA=FF) -> mem[0] unchanged, verified after returning to IDLE by readback execution.
5. `RUN` dropped in TGT -> IDLE next cycle, `PL`=FF and `PL_E`=1, `Addr`=0; no `OP_V`; restart executes from 0.
6. `RST` during HALT -> `HALTED`=0, `FETCH_CNT`=0, `OP_V`=0; store preserved; rerun reproduces scenario 1.

Source files
------------

// File: rtl/ins_fetch_responder.sv
// Opcode responder for the ROM-less core: it holds a writable 256x8 program store,
// decodes jump and halt opcodes, and steers the PC through PL/PL_E.
module ins_fetch_responder #(
  parameter logic [7:0] JMP_OPCODE  = 8'hF0,
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter int         CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       Addr,
  output logic [7:0]       PL,
  output logic             PL_E,
  input  logic             RUN,
  input  logic             WE,
  input  logic [7:0]       WADDR,
  input  logic [7:0]       WDATA,
  output logic [7:0]       OP,
  output logic             OP_V,
  output logic             HALTED,
  output logic [CNT_W-1:0] FETCH_CNT
);

  // state  | meaning
  // IDLE   | PC parked at Addr=0, program store writable
  // EXEC   | issue mem[Addr], or decode jump/halt
  // TGT    | mem[Addr] is a jump target, load PC with it
  // HALT   | PC held on the halt byte until RUN drops
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_TGT  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [7:0]       mem_q [256];
  logic [1:0]       state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic             op_v_q, op_v_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_byte;
  logic             mem_we;

  assign rd_byte = mem_q[Addr];
  assign mem_we  = WE && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op_v_d  = 1'b0;
    cnt_d   = cnt_q;
    PL      = 8'hFF;
    PL_E    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!RUN) begin
          state_d = S_IDLE;
        end else if (rd_byte == HALT_OPCODE) begin
          PL      = Addr - 8'd1;
          state_d = S_HALT;
        end else if (rd_byte == JMP_OPCODE) begin
          PL_E    = 1'b0;
          PL      = 8'h00;
          state_d = S_TGT;
        end else begin
          PL_E   = 1'b0;
          PL     = 8'h00;
          op_d   = rd_byte;
          op_v_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TGT: begin
        if (!RUN) begin
          state_d = S_IDLE;
        end else begin
          // PC adds one after loading, so preload target-1
          PL      = rd_byte - 8'd1;
          state_d = S_EXEC;
        end
      end
      S_HALT: begin
        PL = Addr - 8'd1;
        if (!RUN) state_d = S_IDLE;
      end
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= 8'h00;
      op_v_q   <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      op_v_q   <= op_v_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // store survives reset on purpose
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[WADDR] <= WDATA;
  end

  assign OP        = op_q;
  assign OP_V      = op_v_q;
  assign HALTED    = halted_q;
  assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_ins_fetch_responder.sv
// Bench for ins_fetch_responder: a PC model closes the fetch loop, and an instruction-level
// interpreter expands each program into the expected per-cycle output stream.
module tb_ins_fetch_responder;

  logic        CLK = 1'b0;
  logic        RST, RUN, WE;
  logic [7:0]  WADDR, WDATA;
  logic [7:0]  Addr, PL, OP;
  logic        PL_E, OP_V, HALTED;
  logic [15:0] FETCH_CNT;
  logic [7:0]  pc = 8'hFF;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       op_v;
    logic [7:0] op;
    logic [7:0] addr;
    logic       halted;
    logic       pl_chk;
    logic [7:0] pl;
  } slot_t;

  slot_t       exp_q[$];
  logic [7:0]  mmem [256];
  logic [15:0] m_cnt;
  logic [7:0]  m_last_op;

  ins_fetch_responder dut (
    .CLK(CLK), .RST(RST), .Addr(Addr), .PL(PL), .PL_E(PL_E), .RUN(RUN),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .OP(OP), .OP_V(OP_V),
    .HALTED(HALTED), .FETCH_CNT(FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  // instruction register / PC partner
  always @(posedge CLK) pc <= PL_E ? PL : Addr;
  assign Addr = pc + 8'd1;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
    WE = 1'b1; WADDR = a; WDATA = d;
    step();
    WE = 1'b0;
    mmem[a] = d;
  endtask

  function automatic logic [7:0] rand_plain();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'hF0 || b == 8'hFF) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  // Walk the program from address 0 and list what each clock should show.
  task automatic build_expect(input int n);
    logic [7:0] mpc, t;
    bit stopped;
    mpc = 8'h00;
    stopped = 0;
    exp_q.delete();
    while (exp_q.size() < n) begin
      if (stopped || mmem[mpc] == 8'hFF) begin
        stopped = 1;
        exp_q.push_back('{1'b0, 8'h00, mpc, 1'b1, 1'b0, 8'h00});
      end else if (mmem[mpc] == 8'hF0) begin
        t = mmem[8'(mpc + 8'd1)];
        exp_q.push_back('{1'b0, 8'h00, 8'(mpc + 8'd1), 1'b0, 1'b1, 8'(t - 8'd1)});
        exp_q.push_back('{1'b0, 8'h00, t, 1'b0, 1'b0, 8'h00});
        mpc = t;
      end else begin
        exp_q.push_back('{1'b1, mmem[mpc], 8'(mpc + 8'd1), 1'b0, 1'b0, 8'h00});
        mpc = mpc + 8'd1;
      end
    end
  endtask

  task automatic run_check(input int n, input bit we_noise);
    slot_t s;
    chk("start_addr", Addr, 8'h00);
    build_expect(n);
    RUN = 1'b1;
    step();
    chk("first_opv", OP_V, 1'b0);
    chk("first_addr", Addr, 8'h00);
    for (int i = 0; i < n; i++) begin
      if (we_noise) begin
        WE = 1'b1; WADDR = 8'($urandom); WDATA = 8'hFF;
        if (i == 0) WADDR = 8'h00;
      end
      step();
      s = exp_q.pop_front();
      if (s.op_v) begin
        m_last_op = s.op;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      chk("op_v", OP_V, s.op_v);
      chk("op", OP, m_last_op);
      chk("addr", Addr, s.addr);
      chk("halted", HALTED, s.halted);
      chk("fetch_cnt", FETCH_CNT, m_cnt);
      if (s.pl_chk) begin
        chk("tgt_pl_e", PL_E, 1'b1);
        chk("tgt_pl", PL, s.pl);
      end
    end
    WE = 1'b0;
  endtask

  task automatic stop_run();
    RUN = 1'b0;
    step();
    chk("stop_opv", OP_V, 1'b0);
    chk("stop_halted", HALTED, 1'b0);
    step();
    chk("stop_addr", Addr, 8'h00);
    chk("stop_opv2", OP_V, 1'b0);
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b0; WE = 1'b0; WADDR = 8'h00; WDATA = 8'h00;
    m_cnt = 16'h0; m_last_op = 8'h00;
    step();
    step();
    chk("rst_op", OP, 8'h00);
    chk("rst_opv", OP_V, 1'b0);
    chk("rst_halted", HALTED, 1'b0);
    chk("rst_cnt", FETCH_CNT, 16'h0);
    RST = 1'b0;
    step();
    chk("idle_pl_e", PL_E, 1'b1);
    chk("idle_pl", PL, 8'hFF);
    chk("idle_addr", Addr, 8'h00);

    for (int a = 0; a < 256; a++) write_mem(8'(a), 8'h00);

    // straight-line program ending in halt
    write_mem(8'h00, 8'h01); write_mem(8'h01, 8'h02);
    write_mem(8'h02, 8'h03); write_mem(8'h03, 8'hFF);
    run_check(8, 0);
    chk("halt_cnt", FETCH_CNT, 16'd3);

    // reset while halted, store must survive
    RST = 1'b1; RUN = 1'b0;
    step();
    chk("hrst_halted", HALTED, 1'b0);
    chk("hrst_cnt", FETCH_CNT, 16'h0);
    chk("hrst_opv", OP_V, 1'b0);
    chk("hrst_op", OP, 8'h00);
    RST = 1'b0; m_cnt = 16'h0; m_last_op = 8'h00;
    step();
    run_check(8, 0);
    stop_run();

    // absolute jump then halt
    write_mem(8'h00, 8'hF0); write_mem(8'h01, 8'h10);
    write_mem(8'h10, 8'hAA); write_mem(8'h11, 8'hFF);
    run_check(8, 0);
    stop_run();

    // jump to 0 loop, with write attempts while running
    write_mem(8'h00, 8'h05); write_mem(8'h01, 8'hF0); write_mem(8'h02, 8'h00);
    run_check(12, 1);
    stop_run();
    run_check(12, 0);
    stop_run();

    // RUN dropped while in TGT
    write_mem(8'h00, 8'hF0); write_mem(8'h01, 8'h10);
    RUN = 1'b1;
    step();
    step();
    chk("tgt_addr", Addr, 8'h01);
    chk("tgt_pl_0f", PL, 8'h0F);
    chk("tgt_pl_e1", PL_E, 1'b1);
    RUN = 1'b0;
    #1;
    chk("abort_pl", PL, 8'hFF);
    chk("abort_pl_e", PL_E, 1'b1);
    step();
    chk("abort_addr", Addr, 8'h00);
    chk("abort_opv", OP_V, 1'b0);
    chk("abort_halted", HALTED, 1'b0);
    step();
    run_check(6, 0);
    stop_run();

    // random programs
    for (int p = 0; p < 10; p++) begin
      for (int a = 0; a < 32; a++) begin
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 9);
        if (r < 7)       b = rand_plain();
        else if (r == 7) b = 8'hF0;
        else if (r == 8) b = 8'hFF;
        else             b = 8'($urandom_range(0, 31));
        write_mem(8'(a), b);
      end
      run_check(40, p[0]);
      stop_run();
    end

    // counter saturation and PC wrap 255->0 on an all-plain store
    RST = 1'b1;
    step();
    RST = 1'b0; m_cnt = 16'h0; m_last_op = 8'h00;
    for (int a = 0; a < 256; a++) write_mem(8'(a), rand_plain());
    run_check(65540, 0);
    chk("sat_cnt", FETCH_CNT, 16'hFFFF);
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
